// File: rtl/write_back_stage_pkg.sv
// Shared decode constants for the write-back stage so decode/execute decode
// instructions identically.
package write_back_stage_pkg;

  localparam int DATA_W = 20;
  localparam int NREGS  = 16;
  localparam int REG_W  = $clog2(NREGS);
  localparam int CNT_W  = 20;

  localparam int OPC_HI = 19;
  localparam int OPC_LO = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 12;

  localparam logic [3:0] OP_NOP       = 4'h0;
  localparam logic [3:0] OP_LD        = 4'h1;
  localparam logic [3:0] OP_ST        = 4'h2;
  localparam logic [3:0] OP_ALU_FIRST = 4'h3;
  localparam logic [3:0] OP_ALU_LAST  = 4'hB;
  localparam logic [3:0] OP_BR_FIRST  = 4'hC;

  function automatic logic is_alu(input logic [3:0] op);
    return (op >= OP_ALU_FIRST) && (op <= OP_ALU_LAST);
  endfunction

  function automatic logic writes_rd(input logic [3:0] op);
    return (op == OP_LD) || is_alu(op);
  endfunction

endpackage

// File: rtl/write_back_stage_register_file_2r1w.sv
// Two-read one-write register file; r0 reads zero, and a same-cycle write
// is bypassed onto the read ports.
module register_file_2r1w #(
  parameter int DATA_W = 20,
  parameter int NREGS  = 16,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     rs1_addr,
  input  logic [AW-1:0]     rs2_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data
);

  logic [DATA_W-1:0] mem [NREGS];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rs1_data = '0;
    if (rs1_addr != '0) begin
      if (we && (rs1_addr == waddr)) rs1_data = wdata;
      else                           rs1_data = mem[rs1_addr];
    end
  end

  always_comb begin
    rs2_data = '0;
    if (rs2_addr != '0) begin
      if (we && (rs2_addr == waddr)) rs2_data = wdata;
      else                           rs2_data = mem[rs2_addr];
    end
  end

endmodule

// File: rtl/write_back_stage.sv
// Final pipeline stage: MEM/WB register, register file with write-back
// bypass, and a retired-instruction counter. No back-pressure.
module write_back_stage
  import write_back_stage_pkg::*;
#(
  parameter int DATA_W = write_back_stage_pkg::DATA_W,
  parameter int NREGS  = write_back_stage_pkg::NREGS,
  parameter int CNT_W  = write_back_stage_pkg::CNT_W,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_instruction,
  input  logic [DATA_W-1:0] in_address,
  input  logic              in_write_enable,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              flush,
  input  logic [AW-1:0]     rs1_addr,
  input  logic [AW-1:0]     rs2_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [AW-1:0]     wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic [CNT_W-1:0]  retired_count
);

  logic              valid_q;
  logic [DATA_W-1:0] instr_q;
  logic [DATA_W-1:0] addr_q;
  logic              store_q;
  logic [CNT_W-1:0]  retired_q;
  logic [3:0]        opcode;
  logic              unused_bits;

  // Flush and in_valid=0 both load an all-zero bubble, which decodes as NOP.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      addr_q  <= '0;
      store_q <= 1'b0;
    end else if (in_valid && !flush) begin
      valid_q <= 1'b1;
      instr_q <= in_instruction;
      addr_q  <= in_address;
      store_q <= in_write_enable;
    end else begin
      valid_q <= 1'b0;
      instr_q <= '0;
      addr_q  <= '0;
      store_q <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)     retired_q <= '0;
    else if (valid_q) retired_q <= retired_q + 1'b1;
  end

  assign opcode = instr_q[OPC_HI:OPC_LO];
  assign wb_rd  = instr_q[RD_HI:RD_LO];

  // Load data arrives from memory in this cycle, so it is taken live.
  always_comb begin
    wb_data = '0;
    if (opcode == OP_LD)  wb_data = mem_rdata;
    else if (is_alu(opcode)) wb_data = addr_q;
  end

  assign wb_valid      = valid_q;
  assign wb_we         = valid_q && writes_rd(opcode) && (wb_rd != '0);
  assign retired_count = retired_q;
  assign unused_bits   = ^{store_q, instr_q[RD_LO-1:0]};

  register_file_2r1w #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .AW     (AW)
  ) u_regfile (
    .clock    (clock),
    .reset_n  (reset_n),
    .we       (wb_we),
    .waddr    (wb_rd),
    .wdata    (wb_data),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data)
  );

endmodule

// File: tb/tb_write_back_stage.sv
// Bench for write_back_stage: directed instructions feed an expected queue
// that a negedge monitor drains whenever wb_valid is presented.
module tb_write_back_stage;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic [19:0] in_instruction;
  logic [19:0] in_address;
  logic        in_write_enable;
  logic [19:0] mem_rdata;
  logic        flush;
  logic [3:0]  rs1_addr;
  logic [3:0]  rs2_addr;
  logic [19:0] rs1_data;
  logic [19:0] rs2_data;
  logic        wb_valid;
  logic        wb_we;
  logic [3:0]  wb_rd;
  logic [19:0] wb_data;
  logic [19:0] retired_count;

  // expected entry: {we, rd, data}
  logic [24:0] exp_q[$];
  logic [19:0] exp_cnt;
  int          n_checks;
  int          n_pass;

  write_back_stage dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .in_valid        (in_valid),
    .in_instruction  (in_instruction),
    .in_address      (in_address),
    .in_write_enable (in_write_enable),
    .mem_rdata       (mem_rdata),
    .flush           (flush),
    .rs1_addr        (rs1_addr),
    .rs2_addr        (rs2_addr),
    .rs1_data        (rs1_data),
    .rs2_data        (rs2_data),
    .wb_valid        (wb_valid),
    .wb_we           (wb_we),
    .wb_rd           (wb_rd),
    .wb_data         (wb_data),
    .retired_count   (retired_count)
  );

  // clock / watchdog
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  // Expected write-back for an accepted instruction, from the opcode table.
  function automatic logic [24:0] model(input logic [19:0] ins, input logic [19:0] adr,
                                        input logic [19:0] rword);
    logic [3:0]  op;
    logic [3:0]  rd;
    logic [19:0] data;
    logic        wr;
    op   = ins[19:16];
    rd   = ins[15:12];
    wr   = (op == 4'h1) || (op >= 4'h3 && op <= 4'hB);
    data = (op == 4'h1) ? rword : ((op >= 4'h3 && op <= 4'hB) ? adr : 20'h0);
    return {wr && (rd != 4'h0), rd, data};
  endfunction

  // Drive one instruction at negedge; returns #1 after the capturing edge
  // (cycle N+1) with inputs idled and mem_rdata carrying the load word.
  task automatic step(input logic v, input logic [19:0] ins, input logic [19:0] adr,
                      input logic [19:0] rword, input logic fl);
    @(negedge clock);
    in_valid        = v;
    in_instruction  = ins;
    in_address      = adr;
    in_write_enable = (ins[19:16] == 4'h2);
    flush           = fl;
    @(posedge clock);
    #1;
    in_valid        = 1'b0;
    flush           = 1'b0;
    in_instruction  = 20'($urandom_range(0, 20'hFFFFF));
    in_address      = 20'($urandom_range(0, 20'hFFFFF));
    in_write_enable = 1'($urandom_range(0, 1));
    mem_rdata       = rword;
    if (v && !fl) begin
      exp_q.push_back(model(ins, adr, rword));
      exp_cnt = exp_cnt + 20'h1;
    end
  endtask

  task automatic idle();
    @(posedge clock);
    #1;
  endtask

  task automatic read1(input string name, input logic [3:0] a, input logic [19:0] exp);
    rs1_addr = a;
    #1;
    chk(name, {12'h0, rs1_data}, {12'h0, exp});
  endtask

  task automatic read2(input string name, input logic [3:0] a, input logic [19:0] exp);
    rs2_addr = a;
    #1;
    chk(name, {12'h0, rs2_data}, {12'h0, exp});
  endtask

  // scoreboard monitor
  always @(negedge clock) begin
    if (reset_n) begin
      if (wb_valid) begin
        if (exp_q.size() == 0) begin
          chk("wb_unexpected_valid", 32'(wb_valid), 32'h0);
        end else begin
          logic [24:0] e;
          e = exp_q.pop_front();
          chk("wb_we", 32'(wb_we), 32'(e[24]));
          chk("wb_rd", 32'(wb_rd), 32'(e[23:20]));
          chk("wb_data", 32'(wb_data), 32'(e[19:0]));
        end
      end else begin
        chk("bubble_we", 32'(wb_we), 32'h0);
      end
    end
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    exp_cnt  = 20'h0;
    // reset with arbitrary inputs
    reset_n         = 1'b0;
    in_valid        = 1'b1;
    in_instruction  = 20'h3ABCD;
    in_address      = 20'h54321;
    in_write_enable = 1'b1;
    mem_rdata       = 20'hFFFFF;
    flush           = 1'b0;
    rs1_addr        = 4'h3;
    rs2_addr        = 4'hA;
    repeat (3) @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    reset_n  = 1'b1;
    idle();
    chk("rst_wb_valid", 32'(wb_valid), 32'h0);
    chk("rst_wb_we", 32'(wb_we), 32'h0);
    chk("rst_wb_rd", 32'(wb_rd), 32'h0);
    chk("rst_wb_data", 32'(wb_data), 32'h0);
    chk("rst_count", 32'(retired_count), 32'h0);
    read1("rst_rs1_r5", 4'h5, 20'h0);
    read2("rst_rs2_r10", 4'hA, 20'h0);

    // ALU op3 rd4: bypass in N+1, array in N+2
    rs1_addr = 4'h4;
    step(1'b1, 20'h34000, 20'h0ABCD, 20'h0, 1'b0);
    chk("alu_we_n1", 32'(wb_we), 32'h1);
    read1("alu_bypass_r4", 4'h4, 20'h0ABCD);
    idle();
    chk("alu_we_n2", 32'(wb_we), 32'h0);
    read1("alu_array_r4", 4'h4, 20'h0ABCD);

    // LD rd7, then ST and branch naming rd7 must not disturb it
    step(1'b1, 20'h17000, 20'h00010, 20'h12345, 1'b0);
    read2("ld_bypass_r7", 4'h7, 20'h12345);
    step(1'b1, 20'h27000, 20'hFFFFF, 20'h0AAAA, 1'b0);
    chk("st_we", 32'(wb_we), 32'h0);
    step(1'b1, 20'hC7000, 20'h00F00, 20'h05555, 1'b0);
    chk("br_we", 32'(wb_we), 32'h0);
    idle();
    read2("r7_after_st_br", 4'h7, 20'h12345);
    read1("r4_untouched", 4'h4, 20'h0ABCD);

    // last ALU opcode into top register
    step(1'b1, 20'hBF000, 20'h13579, 20'h0, 1'b0);
    idle();
    read1("aluB_r15", 4'hF, 20'h13579);

    // write to r0 is dropped but still retires
    step(1'b1, 20'h50000, 20'hFFFFF, 20'h0, 1'b0);
    chk("r0_we", 32'(wb_we), 32'h0);
    read1("r0_reads_zero", 4'h0, 20'h0);
    idle();
    chk("count_after_r0", 32'(retired_count), 32'(exp_cnt));

    // flush kills the ALU op, in-flight LD still writes
    step(1'b1, 20'h18000, 20'h00020, 20'h0BEEF, 1'b0);
    step(1'b1, 20'h38000, 20'h00777, 20'h0, 1'b1);
    chk("flush_valid", 32'(wb_valid), 32'h0);
    idle();
    read1("flush_ld_r8", 4'h8, 20'h0BEEF);
    chk("count_after_flush", 32'(retired_count), 32'(exp_cnt));

    // counter wrap
    idle();
    force dut.retired_q = 20'hFFFFE;
    #1;
    release dut.retired_q;
    exp_cnt = 20'hFFFFE;
    step(1'b1, 20'h00000, 20'h0, 20'h0, 1'b0);
    step(1'b1, 20'h00000, 20'h0, 20'h0, 1'b0);
    step(1'b1, 20'h00000, 20'h0, 20'h0, 1'b0);
    idle();
    chk("count_wrap", 32'(retired_count), 32'h00001);
    chk("count_wrap_model", 32'(retired_count), 32'(exp_cnt));

    // reset mid-cycle while a write to r9 is pending
    rs1_addr = 4'h9;
    step(1'b1, 20'h49000, 20'h55555, 20'h0, 1'b0);
    chk("pend_we", 32'(wb_we), 32'h1);
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    exp_cnt = 20'h0;
    #1;
    chk("midrst_valid", 32'(wb_valid), 32'h0);
    chk("midrst_we", 32'(wb_we), 32'h0);
    chk("midrst_data", 32'(wb_data), 32'h0);
    chk("midrst_count", 32'(retired_count), 32'h0);
    chk("midrst_rs1_r9", 32'(rs1_data), 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    idle();
    idle();
    read1("r9_lost", 4'h9, 20'h0);
    read2("r4_cleared", 4'h4, 20'h0);

    idle();
    chk("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
